// File: rtl/division_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and default width.
// No logic, no timing.
package division_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/division_step.sv
// One restoring-division step: shift in the next dividend bit and subtract the divisor when it fits.
// Purely combinational; the only subtractor in the divider datapath.
module division_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign trial = {rem, bit_in};
    assign diff  = trial - {1'b0, divisor};

    // rem < divisor, so a non-negative difference always fits back in WIDTH bits
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/division_gen.sv
// Signed/unsigned radix-2 restoring divider, one quotient bit per clock.
// Latency WIDTH+2 clocks (2 for divide-by-zero and MIN/-1); start is ignored while busy.
module division_gen
    import division_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   D,
    output logic [2*WIDTH-1:0] R,
    output logic               busy,
    output logic               done,
    output logic               dz,
    output logic               ovf
);

    localparam int              CW      = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES    = '1;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             special;
    logic             ovf_cond;
    logic             sgn_q;
    logic             q_neg;
    logic             r_neg;
    logic             dz_hit;
    logic             ovf_hit;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] d_raw;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] d_mag;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo;
    logic             q_bit;
    logic [CW-1:0]    cnt;

    assign accept   = start && (state == ST_IDLE || state == ST_DONE);
    assign ovf_cond = sgn_q && (a_raw == MIN_VAL) && (d_raw == ONES);
    assign special  = (d_raw == '0) || ovf_cond;

    division_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .divisor  (d_mag),
        .bit_in   (a_sh[WIDTH-1]),
        .rem_next (rem_nxt),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_PREP;
            // exceptional operands skip CALC but still go through the common R load in FIX
            ST_PREP: state_nxt = special ? ST_FIX : ST_CALC;
            ST_CALC: if (cnt == LAST) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = accept ? ST_PREP : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_PREP) || (state == ST_CALC) || (state == ST_FIX);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_raw   <= '0;
            d_raw   <= '0;
            sgn_q   <= 1'b0;
            a_sh    <= '0;
            d_mag   <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dz_hit  <= 1'b0;
            ovf_hit <= 1'b0;
            R       <= '0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (accept) begin
                a_raw <= A;
                d_raw <= D;
                sgn_q <= sgn;
            end
            case (state)
                ST_PREP: begin
                    a_sh    <= (sgn_q && a_raw[WIDTH-1]) ? -a_raw : a_raw;
                    d_mag   <= (sgn_q && d_raw[WIDTH-1]) ? -d_raw : d_raw;
                    q_neg   <= sgn_q && (a_raw[WIDTH-1] ^ d_raw[WIDTH-1]);
                    r_neg   <= sgn_q && a_raw[WIDTH-1];
                    dz_hit  <= (d_raw == '0);
                    ovf_hit <= ovf_cond;
                    rem     <= '0;
                    quo     <= '0;
                    cnt     <= '0;
                end
                ST_CALC: begin
                    a_sh <= a_sh << 1;
                    rem  <= rem_nxt;
                    quo  <= {quo[WIDTH-2:0], q_bit};
                    cnt  <= cnt + 1'b1;
                end
                ST_FIX: begin
                    dz  <= dz_hit;
                    ovf <= ovf_hit;
                    if (dz_hit) begin
                        R <= {a_raw, ONES};
                    end else if (ovf_hit) begin
                        R <= {{WIDTH{1'b0}}, MIN_VAL};
                    end else begin
                        R <= {(r_neg ? -rem : rem), (q_neg ? -quo : quo)};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_division_gen.sv
// Scoreboard bench for division_gen at WIDTH=32 and WIDTH=8 with directed operands.
module tb_division_gen;

    typedef struct {
        logic [63:0] r;
        logic        dz;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start32 = 1'b0, sgn32 = 1'b0;
    logic [31:0] a32 = '0, d32 = '0;
    logic [63:0] r32;
    logic        busy32, done32, dz32, ovf32;
    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, d8 = '0;
    logic [15:0] r8;
    logic        busy8, done8, dz8, ovf8;

    exp_t q32[$];
    exp_t q8[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    division_gen #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .sgn(sgn32), .A(a32), .D(d32),
        .R(r32), .busy(busy32), .done(done32), .dz(dz32), .ovf(ovf32)
    );

    division_gen #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .A(a8), .D(d8),
        .R(r8), .busy(busy8), .done(done8), .dz(dz8), .ovf(ovf8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // monitors: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (done32 === 1'b1) begin
            if (q32.size() == 0) begin
                chk("unexpected_done32", 64'(done32), 64'd0);
            end else begin
                e = q32.pop_front();
                chk("r32", r32, e.r);
                chk("dz32", 64'(dz32), 64'(e.dz));
                chk("ovf32", 64'(ovf32), 64'(e.ovf));
                chk("latency32", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", 64'(done8), 64'd0);
            end else begin
                e = q8.pop_front();
                chk("r8", {48'd0, r8}, e.r);
                chk("dz8", 64'(dz8), 64'(e.dz));
                chk("ovf8", 64'(ovf8), 64'(e.ovf));
                chk("latency8", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic push32(input logic [63:0] r, input logic ez, input logic eo, input int lat);
        exp_t e;
        e.r = r; e.dz = ez; e.ovf = eo; e.cyc = cyc + 1 + lat;
        q32.push_back(e);
    endtask

    task automatic go32(input logic [31:0] a, input logic [31:0] d, input logic s,
                        input logic [63:0] r, input logic ez, input logic eo, input int lat);
        a32 = a; d32 = d; sgn32 = s; start32 = 1'b1;
        push32(r, ez, eo, lat);
        @(posedge clk); #1 start32 = 1'b0;
        chk("busy32_after_start", 64'(busy32), 64'd1);
    endtask

    task automatic go8(input logic [7:0] a, input logic [7:0] d, input logic s,
                       input logic [15:0] r, input logic ez, input logic eo, input int lat);
        exp_t e;
        a8 = a; d8 = d; sgn8 = s; start8 = 1'b1;
        e.r = {48'd0, r}; e.dz = ez; e.ovf = eo; e.cyc = cyc + 1 + lat;
        q8.push_back(e);
        @(posedge clk); #1 start8 = 1'b0;
        chk("busy8_after_start", 64'(busy8), 64'd1);
    endtask

    task automatic drain32(input int budget);
        int n = 0;
        while (q32.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain32_pending", 64'(q32.size()), 64'd0);
        q32.delete();
        @(posedge clk); #1;
    endtask

    task automatic drain8(input int budget);
        int n = 0;
        while (q8.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain8_pending", 64'(q8.size()), 64'd0);
        q8.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        chk("reset_r32", r32, 64'd0);
        chk("reset_busy32", 64'(busy32), 64'd0);
        chk("reset_done32", 64'(done32), 64'd0);
        chk("reset_flags32", {62'd0, dz32, ovf32}, 64'd0);
        chk("reset_r8", {48'd0, r8}, 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // 100/3, then a new start presented during DONE (20/6) begins immediately
        go32(32'd100, 32'd3, 1'b0, {32'd1, 32'd33}, 1'b0, 1'b0, 34);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done32) break;
        end
        a32 = 32'd20; d32 = 32'd6; sgn32 = 1'b0; start32 = 1'b1;
        push32({32'd2, 32'd3}, 1'b0, 1'b0, 34);
        @(posedge clk); #1 start32 = 1'b0;
        chk("busy32_back_to_back", 64'(busy32), 64'd1);
        drain32(100);

        go32(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 1'b0, 34);
        drain32(100);
        go32(32'd7, 32'hFFFFFFFE, 1'b1, {32'd1, 32'hFFFFFFFD}, 1'b0, 1'b0, 34);
        drain32(100);
        go32(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, {32'hFFFFFFFE, 32'd14}, 1'b0, 1'b0, 34);
        drain32(100);
        go32(32'd5, 32'd0, 1'b0, {32'd5, 32'hFFFFFFFF}, 1'b1, 1'b0, 2);
        drain32(100);
        go32(32'd5, 32'd0, 1'b1, {32'd5, 32'hFFFFFFFF}, 1'b1, 1'b0, 2);
        drain32(100);
        go32(32'h80000000, 32'hFFFFFFFF, 1'b0, {32'h80000000, 32'd0}, 1'b0, 1'b0, 34);
        drain32(100);
        go32(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'd0, 32'h80000000}, 1'b0, 1'b1, 2);
        drain32(100);

        // WIDTH=8 with a start pulse in the middle of CALC that must be ignored
        go8(8'd200, 8'd7, 1'b0, {8'd4, 8'd28}, 1'b0, 1'b0, 10);
        repeat (3) @(posedge clk);
        #1 a8 = 8'd1; d8 = 8'd1; sgn8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        drain8(40);
        go8(8'h80, 8'hFF, 1'b1, {8'h00, 8'h80}, 1'b0, 1'b1, 2);
        drain8(40);

        // abort mid-CALC: outputs clear at once and no done ever appears
        a32 = 32'd100; d32 = 32'd3; sgn32 = 1'b0; start32 = 1'b1;
        @(posedge clk); #1 start32 = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("abort_r32", r32, 64'd0);
        chk("abort_busy32", 64'(busy32), 64'd0);
        chk("abort_done32", 64'(done32), 64'd0);
        chk("abort_flags32", {62'd0, dz32, ovf32}, 64'd0);
        chk("abort_r8", {48'd0, r8}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (40) @(posedge clk);
        #1 chk("idle_after_abort_busy32", 64'(busy32), 64'd0);

        go32(32'd12345678, 32'd1234, 1'b0, {32'd742, 32'd10004}, 1'b0, 1'b0, 34);
        drain32(100);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
